pwm_gpio_top: RTL and testbench

- Top-level 3-channel PWM generator whose channels drive the GPIO pad outputs.
- A shared prescaler produces a tick enable. Each channel has its own period counter, and each channel's output is high while its counter is below a common duty threshold.
- It sits at chip top, between configuration inputs (driven by a register block or bench) and the pads.

---
 rtl/pwm_gpio_pkg.sv | 7 +
 rtl/pwm_channel.sv | 47 ++++
 rtl/pwm_gpio_top.sv | 51 +++++
 tb/tb_pwm_gpio_top.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/pwm_gpio_pkg.sv
// Shared constants and types for the GPIO PWM block.
package pwm_gpio_pkg;
  localparam int NCH_DEFAULT = 3;
  localparam int W_DEFAULT   = 32;

  typedef logic [W_DEFAULT-1:0] cnt_t;
endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: period counter, wrap logic and registered output.
module pwm_channel
  import pwm_gpio_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         tick_i,
  input  logic [W-1:0] period_i,
  input  logic [W-1:0] duty_i,
  output logic         out_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         out_q, out_d;
  logic         per_nz;

  assign per_nz = (period_i != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || !per_nz) begin
      cnt_d = '0;
    end else if (tick_i) begin
      // >= so a period shrunk below the current count wraps instead of running away
      if (cnt_q >= period_i - 1'b1) cnt_d = '0;
      else                          cnt_d = cnt_q + 1'b1;
    end
  end

  assign out_d = en_i & per_nz & (cnt_q < duty_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/pwm_gpio_top.sv
// Multi-channel PWM driving GPIO pads; a shared prescaler paces every channel counter.
module pwm_gpio_top
  import pwm_gpio_pkg::*;
#(
  parameter int NCH = NCH_DEFAULT,
  parameter int W   = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] enable_i,
  input  logic [W-1:0]   prescaler_i,
  input  logic [W-1:0]   pwm_period_i,
  input  logic [W-1:0]   duty_cycle_i,
  output logic [W-1:0]   pwm_o,
  output logic [NCH-1:0] io
);

  logic [W-1:0]   pre_cnt_q, pre_cnt_d;
  logic           any_en, tick;
  logic [NCH-1:0] ch_out;

  assign any_en = |enable_i;
  // >= lets a shrinking prescaler recover within one cycle
  assign tick   = any_en && (pre_cnt_q >= prescaler_i);

  always_comb begin
    pre_cnt_d = pre_cnt_q + 1'b1;
    if (!any_en || tick) pre_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) pre_cnt_q <= '0;
    else     pre_cnt_q <= pre_cnt_d;
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    pwm_channel #(.W(W)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en_i     (enable_i[k]),
      .tick_i   (tick),
      .period_i (pwm_period_i),
      .duty_i   (duty_cycle_i),
      .out_o    (ch_out[k])
    );
  end

  assign io    = ch_out;
  assign pwm_o = {{(W-NCH){1'b0}}, ch_out};

endmodule

// File: tb/tb_pwm_gpio_top.sv
// Directed bench for pwm_gpio_top with hand-derived waveforms.
module tb_pwm_gpio_top;
  import pwm_gpio_pkg::*;

  localparam int NCH = NCH_DEFAULT;
  localparam int W   = W_DEFAULT;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] enable_i;
  cnt_t           prescaler_i, pwm_period_i, duty_cycle_i;
  logic [W-1:0]   pwm_o;
  logic [NCH-1:0] io;

  int nchk = 0;
  int nerr = 0;

  pwm_gpio_top #(.NCH(NCH), .W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable_i),
    .prescaler_i  (prescaler_i),
    .pwm_period_i (pwm_period_i),
    .duty_cycle_i (duty_cycle_i),
    .pwm_o        (pwm_o),
    .io           (io)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one edge and sample just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [NCH-1:0] exp);
    chk({tag, " io"}, 32'(io), 32'(exp));
    chk({tag, " pwm_o"}, pwm_o, 32'(exp));
  endtask

  task automatic cfg(input logic [NCH-1:0] en, input int pre, input int per, input int dty);
    enable_i     = en;
    prescaler_i  = cnt_t'(pre);
    pwm_period_i = cnt_t'(per);
    duty_cycle_i = cnt_t'(dty);
  endtask

  // one edge with everything disabled: clears counters and checks low output
  task automatic idle(input string tag);
    enable_i = '0;
    step();
    chk_out(tag, 3'b000);
  endtask

  task automatic run_const(input string tag, input int per, input int dty, input logic [NCH-1:0] exp);
    idle({tag, " idle"});
    cfg(3'b111, 0, per, dty);
    for (int i = 0; i < 8; i++) begin
      step();
      chk_out(tag, exp);
    end
  endtask

  initial begin
    logic [NCH-1:0] e;

    // reset held with enables on
    rst = 1'b1;
    cfg(3'b111, 0, 4, 1);
    for (int i = 0; i < 15; i++) begin
      step();
      chk_out("reset", 3'b000);
    end
    rst = 1'b0;
    cfg(3'b000, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("post_reset", 3'b000);
    end

    // basic 1-of-4 waveform on channel 0
    cfg(3'b001, 0, 4, 1);
    for (int i = 0; i < 12; i++) begin
      step();
      chk_out("basic", (i % 4 == 0) ? 3'b001 : 3'b000);
    end

    // prescaler=2: 3 clk per tick, 6 high / 6 low, all in phase
    idle("pre idle");
    cfg(3'b111, 2, 4, 2);
    for (int i = 0; i < 24; i++) begin
      step();
      chk_out("prescale", ((i % 12) < 6) ? 3'b111 : 3'b000);
    end

    run_const("duty0",    4, 0, 3'b000);
    run_const("duty_eq",  4, 4, 3'b111);
    run_const("period0",  0, 3, 3'b000);
    run_const("duty_gt",  4, 7, 3'b111);

    // enable toggle on channel 1 while channel 0 runs on
    idle("tog idle");
    cfg(3'b011, 0, 4, 2);
    for (int i = 0; i < 15; i++) begin
      if (i == 5) enable_i = 3'b001;
      if (i == 7) enable_i = 3'b011;
      step();
      e[0] = (i % 4) < 2;
      e[1] = (i < 5) ? ((i % 4) < 2) : (i < 7) ? 1'b0 : (((i - 7) % 4) < 2);
      e[2] = 1'b0;
      chk_out("toggle", e);
    end

    // period 8 -> 3 while cnt=6
    idle("rt idle");
    cfg(3'b001, 0, 8, 1);
    for (int i = 0; i < 16; i++) begin
      if (i == 6) pwm_period_i = cnt_t'(3);
      step();
      if (i < 7) e = (i == 0) ? 3'b001 : 3'b000;
      else       e = (((i - 7) % 3) == 0) ? 3'b001 : 3'b000;
      chk_out("runtime", e);
    end

    // reset mid-operation wins, then channel restarts from count 0
    cfg(3'b111, 0, 4, 4);
    step();
    chk_out("pre_rst", 3'b111);
    rst = 1'b1;
    step();
    chk_out("mid_rst", 3'b000);
    rst = 1'b0;
    step();
    chk_out("after_rst", 3'b111);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
